// File: rtl/axi_write_pkg.sv
// Shared types for the low-priority AXI-lite write path: request entry and queue FSM states.
package axi_write_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wq_state_t;

endpackage

// File: rtl/adam_seq.sv
// Sequencing bundle: single clock plus asynchronous active-low reset.
interface ADAM_SEQ;
    logic clk;
    logic rst;

    modport Master (output clk, output rst);
    modport Slave  (input clk, input rst);
endinterface

// File: rtl/wq_fifo_mem.sv
// Entry storage for the write queue: one synchronous write port, one asynchronous read port.
// Zero-latency read; no flow control of its own, the owner gates i_we.
module wq_fifo_mem
    import axi_write_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = wr_req_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  T              i_wdat,
    input  logic [AW-1:0] i_raddr,
    output T              o_rdat
);

    T r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/fsm_write_queue.sv
// Buffers control-FSM writes and presents the head on req/ack; head visible 1 cycle after push.
// push_ready_o drops when full (registered state only); pushes while full are dropped and flagged.
module fsm_write_queue
    import axi_write_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int TIMEOUT = 1024,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int WW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    ADAM_SEQ.Slave              seq_port,
    input  logic                push_valid_i,
    input  logic [ADDR_W-1:0]   push_addr_i,
    input  logic [DATA_W-1:0]   push_data_i,
    output logic                push_ready_o,
    output logic                fsm_req_o,
    output logic [ADDR_W-1:0]   fsm_adress_o,
    output logic [DATA_W-1:0]   fsm_data_o,
    input  logic                fsm_ack_i,
    input  logic                flush_i,
    input  logic                clear_err_i,
    output logic [CW-1:0]       count_o,
    output logic                overflow_o,
    output logic                timeout_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    logic      w_clk;
    logic      w_rst_n;
    assign w_clk   = seq_port.clk;
    assign w_rst_n = seq_port.rst;

    wq_state_t      r_state, w_state_nxt;
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CW-1:0]  r_count, w_count_nxt;
    logic [WW-1:0]  r_wd, w_wd_nxt;
    logic           r_overflow, r_timeout;
    logic           w_full, w_flush, w_push, w_pop, w_ovf_set, w_to_set;
    entry_t         w_head, w_wdat;

    always_comb begin
        w_full    = (r_count == FULL_CNT);
        w_flush   = flush_i && (r_state == ISSUE);
        w_push    = push_valid_i && !w_full && !w_flush;
        w_pop     = fsm_ack_i && (r_count != '0);
        w_ovf_set = push_valid_i && w_full && !w_flush;
    end

    // Flush keeps only the head: it may already be latched by the port.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
        w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
        if (w_flush) begin
            w_wr_ptr_nxt = r_rd_ptr + PW'(1);
            w_count_nxt  = w_pop ? '0 : CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_nxt = ISSUE;
            ISSUE:   if (w_count_nxt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Timeout flags only the cycle the counter reaches its limit, so a clear sticks while stalled.
    always_comb begin
        w_wd_nxt = r_wd;
        if (TIMEOUT == 0 || r_state != ISSUE || fsm_ack_i || w_flush) begin
            w_wd_nxt = '0;
        end else if (r_wd != WD_MAX) begin
            w_wd_nxt = r_wd + WW'(1);
        end
        w_to_set = (TIMEOUT != 0) && (w_wd_nxt == WD_MAX) && (r_wd != WD_MAX);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wd       <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wd <= w_wd_nxt;
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (clear_err_i) r_overflow <= 1'b0;
            if (w_to_set)         r_timeout  <= 1'b1;
            else if (clear_err_i) r_timeout  <= 1'b0;
        end
    end

    assign w_wdat.addr = push_addr_i;
    assign w_wdat.data = push_data_i;

    wq_fifo_mem #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_mem (
        .i_clk   (w_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdat  (w_wdat),
        .i_raddr (r_rd_ptr),
        .o_rdat  (w_head)
    );

    assign push_ready_o = !w_full;
    assign fsm_req_o    = (r_count != '0);
    assign fsm_adress_o = fsm_req_o ? w_head.addr : '0;
    assign fsm_data_o   = fsm_req_o ? w_head.data : '0;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign timeout_o    = r_timeout;

endmodule
